// File: rtl/rs_write_sequencer.sv
// ---------------------------------------------------------------------------
// rs_write_sequencer
//
// Round-robin sequencer that shares one external rs_write_decodifier between
// two requesters. A granted word is registered onto dec_in for one evaluation
// cycle. The combinational decodifier result on dec_out is then captured and
// offered on a valid/ready output, tagged with the id of the requester.
//
// Parameters
//   W      datapath width, must match the decodifier
//   CNT_W  width of the completed-transfer counter
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   enable                    allows new grants (sampled in IDLE only)
//   req_valid_a/b, req_data_a/b, req_ready_a/b
//                             requester handshakes (ready = word accepted)
//   dec_in  (out)             registered word driven to the decodifier
//   dec_out (in)              combinational decodifier result
//   out_valid, out_data, out_id, out_ready
//                             result handshake; out_id 0 = A, 1 = B
//   busy                      FSM is not IDLE
//   done_count                completed output transfers, wraps
// ---------------------------------------------------------------------------
module rs_write_sequencer #(
    parameter int W     = 12,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             req_valid_a,
    input  logic [W-1:0]     req_data_a,
    output logic             req_ready_a,
    input  logic             req_valid_b,
    input  logic [W-1:0]     req_data_b,
    output logic             req_ready_b,
    output logic [W-1:0]     dec_in,
    input  logic [W-1:0]     dec_out,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic             out_id,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    state_t             state_q,      state_d;
    logic [W-1:0]       dec_in_q,     dec_in_d;
    logic               id_q,         id_d;
    logic               last_grant_q, last_grant_d;
    logic [W-1:0]       out_data_q,   out_data_d;
    logic               out_id_q,     out_id_d;
    logic               out_valid_q,  out_valid_d;
    logic [CNT_W-1:0]   done_count_q, done_count_d;

    logic grant_a;
    logic grant_b;
    logic can_grant;
    logic accept;

    // A lone requester always wins; under contention the one that was not
    // served last wins. last_grant resets to B so A takes the first contest.
    assign grant_a   = req_valid_a & (~req_valid_b | (last_grant_q == ID_B));
    assign grant_b   = req_valid_b & (~req_valid_a | (last_grant_q == ID_A));
    assign can_grant = (state_q == S_IDLE) & enable;
    assign accept    = can_grant & (grant_a | grant_b);

    assign req_ready_a = can_grant & grant_a;
    assign req_ready_b = can_grant & grant_b;

    // Next-state and datapath decode.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        dec_in_d     = dec_in_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;
        out_valid_d  = out_valid_q;
        done_count_d = done_count_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dec_in_d     = grant_b ? req_data_b : req_data_a;
                    id_d         = grant_b ? ID_B : ID_A;
                    last_grant_d = grant_b ? ID_B : ID_A;
                    state_d      = S_EVAL;
                end
            end
            S_EVAL: begin
                // dec_in has been stable for this whole cycle, so dec_out
                // is the settled result for the accepted word.
                out_data_d  = dec_out;
                out_id_d    = id_q;
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d  = 1'b0;
                    done_count_d = done_count_q + CNT_W'(1);
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dec_in_q     <= '0;
            id_q         <= ID_A;
            last_grant_q <= ID_B;
            out_data_q   <= '0;
            out_id_q     <= ID_A;
            out_valid_q  <= 1'b0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            dec_in_q     <= dec_in_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
            out_valid_q  <= out_valid_d;
            done_count_q <= done_count_d;
        end
    end

    assign dec_in     = dec_in_q;
    assign out_data   = out_data_q;
    assign out_id     = out_id_q;
    assign out_valid  = out_valid_q;
    assign done_count = done_count_q;
    assign busy       = (state_q != S_IDLE);

endmodule
